// File: rtl/stage_f_prefetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stage_f_prefetch_if
// Brief    : F-bus, redirect and decode-side signals of the prefetch stage.
//            Optional fault signals exist when STAGE_F_PREFETCH_BUS_ERR_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
interface stage_f_prefetch_if #(
    parameter int AW    = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            f_cyc_o;
    logic [AW-3:0]   f_adr_o;
    logic            f_ack_i;
    logic [31:0]     f_dat_i;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
    logic            f_err_i;
    logic            inst_fault_o;
`endif
    logic            redir_i;
    logic [AW-3:0]   redir_adr_i;
    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [AW-3:0]   inst_pc_o;
    logic            inst_ready_i;
    logic [CW-1:0]   count_o;

    // master: the fetch stage itself; slave: bus + decode environment
    modport master (
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
        input  f_err_i,
        output inst_fault_o,
`endif
        output f_cyc_o, f_adr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        input  f_ack_i, f_dat_i, redir_i, redir_adr_i, inst_ready_i
    );

    modport slave (
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
        output f_err_i,
        input  inst_fault_o,
`endif
        input  f_cyc_o, f_adr_o, inst_valid_o, inst_o, inst_pc_o, count_o,
        output f_ack_i, f_dat_i, redir_i, redir_adr_i, inst_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/stage_f_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : stage_f_prefetch
// Brief    : F-bus instruction fetch with DEPTH-entry prefetch FIFO and redirect.
//            Macro STAGE_F_PREFETCH_BUS_ERR_EN adds bus-error fault entries.
// Revision : 1.0 - initial release
// ============================================================================
module stage_f_prefetch #(
    parameter int            AW           = 64,
    parameter logic [AW-1:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00,
    parameter int            DEPTH        = 4
) (
    input  wire logic                 clk_i,
    input  wire logic                 reset_i,
    stage_f_prefetch_if.master        bus
);
    localparam int               PW      = $clog2(DEPTH);
    localparam int               CW      = PW + 1;
    localparam logic [AW-3:0]    RV_WORD = RESET_VECTOR[AW-1:2];
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);

    logic                run_q,    run_d;
    logic                halt_q,   halt_d;
    logic [AW-3:0]       adr_q,    adr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q,  count_d;
    logic [31:0]         data_q [DEPTH];
    logic [31:0]         data_d [DEPTH];
    logic [AW-3:0]       pc_q   [DEPTH];
    logic [AW-3:0]       pc_d   [DEPTH];
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
    logic [DEPTH-1:0]    fault_q,  fault_d;
`endif

    logic                cyc;
    logic                valid;
    logic                bus_err;
    logic                push;
    logic                pop;

    always_comb begin
        cyc   = run_q && (count_q != FULL) && !halt_q;
        // Head is hidden during a redirect so nothing stale is consumed
        valid = (count_q != '0) && !bus.redir_i;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
        bus_err = cyc && bus.f_err_i;
`else
        bus_err = 1'b0;
`endif
        push = cyc && (bus.f_ack_i || bus_err) && !bus.redir_i;
        pop  = valid && bus.inst_ready_i;

        run_d    = 1'b1;
        halt_d   = halt_q;
        adr_d    = adr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        pc_d     = pc_q;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
        fault_d  = fault_q;
`endif

        if (bus.redir_i) begin
            adr_d    = bus.redir_adr_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            halt_d   = 1'b0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = bus_err ? 32'h0 : bus.f_dat_i;
                pc_d[wr_ptr_q]   = adr_q;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
                fault_d[wr_ptr_q] = bus_err;
`endif
                wr_ptr_d = wr_ptr_q + PW'(1);
                // A faulting fetch freezes the address until the next redirect
                if (bus_err) begin
                    halt_d = 1'b1;
                end else begin
                    adr_d  = adr_q + (AW-2)'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            run_q    <= 1'b0;
            halt_q   <= 1'b0;
            adr_q    <= RV_WORD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
            fault_q  <= '0;
`endif
        end else begin
            run_q    <= run_d;
            halt_q   <= halt_d;
            adr_q    <= adr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            pc_q     <= pc_d;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign bus.f_cyc_o      = cyc;
    assign bus.f_adr_o      = adr_q;
    assign bus.inst_valid_o = valid;
    assign bus.inst_o       = data_q[rd_ptr_q];
    assign bus.inst_pc_o    = pc_q[rd_ptr_q];
    assign bus.count_o      = count_q;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
    assign bus.inst_fault_o = fault_q[rd_ptr_q];
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_f_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_stage_f_prefetch
// Brief    : Directed self-checking bench for stage_f_prefetch (two instances:
//            default reset vector and a wrap-around reset vector).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_f_prefetch;
    localparam logic [63:0] B0 = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] BW = 64'hFFFF_FFFF_FFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst2_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [61:0] wa(input logic [63:0] b);
        return b[63:2];
    endfunction

    // Bus memory model: instruction word derived from its word address
    function automatic logic [31:0] mem_word(input logic [61:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    stage_f_prefetch_if #(.AW(64), .DEPTH(4)) b1 ();
    stage_f_prefetch_if #(.AW(64), .DEPTH(4)) b2 ();

    stage_f_prefetch #(.AW(64), .RESET_VECTOR(B0), .DEPTH(4)) dut1 (
        .clk_i   (clk),
        .reset_i (rst1_n),
        .bus     (b1.master)
    );
    stage_f_prefetch #(.AW(64), .RESET_VECTOR(BW), .DEPTH(4)) dut2 (
        .clk_i   (clk),
        .reset_i (rst2_n),
        .bus     (b2.master)
    );

    assign b1.f_dat_i = mem_word(b1.f_adr_o);
    assign b2.f_dat_i = mem_word(b2.f_adr_o);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1(input logic ack, input logic rdy);
        rst1_n          = 1'b0;
        b1.f_ack_i      = ack;
        b1.inst_ready_i = rdy;
        b1.redir_i      = 1'b0;
        #1;
        chk("rst_cyc",   {63'd0, b1.f_cyc_o}, 64'd0);
        chk("rst_count", {61'd0, b1.count_o}, 64'd0);
        chk("rst_valid", {63'd0, b1.inst_valid_o}, 64'd0);
        tick();
        rst1_n = 1'b1;
        tick();
        chk("start_cyc", {63'd0, b1.f_cyc_o}, 64'd1);
        chk("start_adr", {2'b0, b1.f_adr_o}, {2'b0, wa(B0)});
    endtask

    initial begin
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        b1.f_ack_i = 1'b1; b1.inst_ready_i = 1'b1; b1.redir_i = 1'b0; b1.redir_adr_i = '0;
        b2.f_ack_i = 1'b1; b2.inst_ready_i = 1'b1; b2.redir_i = 1'b0; b2.redir_adr_i = '0;
`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
        b1.f_err_i = 1'b0;
        b2.f_err_i = 1'b0;
`endif
        #1;
        rst1_n = 1'b0;
        rst2_n = 1'b0;

        // ---- reset / start: consecutive fetches, pc one cycle behind ----
        reset1(1'b1, 1'b1);
        tick();
        chk("s_adr1",  {2'b0, b1.f_adr_o},   {2'b0, wa(B0 + 4)});
        chk("s_valid", {63'd0, b1.inst_valid_o}, 64'd1);
        chk("s_pc0",   {2'b0, b1.inst_pc_o}, {2'b0, wa(B0)});
        chk("s_inst0", {32'd0, b1.inst_o},   {32'd0, mem_word(wa(B0))});
        tick();
        chk("s_adr2",  {2'b0, b1.f_adr_o},   {2'b0, wa(B0 + 8)});
        chk("s_pc1",   {2'b0, b1.inst_pc_o}, {2'b0, wa(B0 + 4)});

        // ---- wait states while fetching FF04 ----
        reset1(1'b1, 1'b1);
        tick();
        b1.f_ack_i = 1'b0;
        tick();
        chk("w_adr_a", {2'b0, b1.f_adr_o}, {2'b0, wa(B0 + 4)});
        chk("w_cyc_a", {63'd0, b1.f_cyc_o}, 64'd1);
        tick();
        chk("w_adr_b", {2'b0, b1.f_adr_o}, {2'b0, wa(B0 + 4)});
        chk("w_cnt_b", {61'd0, b1.count_o}, 64'd0);
        b1.f_ack_i = 1'b1;
        tick();
        chk("w_adr_c", {2'b0, b1.f_adr_o},   {2'b0, wa(B0 + 8)});
        chk("w_pc_c",  {2'b0, b1.inst_pc_o}, {2'b0, wa(B0 + 4)});
        chk("w_cnt_c", {61'd0, b1.count_o},  64'd1);
        tick();
        chk("w_pc_d",  {2'b0, b1.inst_pc_o}, {2'b0, wa(B0 + 8)});
        chk("w_cnt_d", {61'd0, b1.count_o},  64'd1);

        // ---- fill / backpressure ----
        reset1(1'b1, 1'b0);
        repeat (4) tick();
        chk("f_cnt4",  {61'd0, b1.count_o},  64'd4);
        chk("f_cyc0",  {63'd0, b1.f_cyc_o},  64'd0);
        chk("f_adr",   {2'b0, b1.f_adr_o},   {2'b0, wa(B0 + 16)});
        chk("f_pc0",   {2'b0, b1.inst_pc_o}, {2'b0, wa(B0)});
        tick();
        chk("f_hold",  {61'd0, b1.count_o},  64'd4);
        b1.inst_ready_i = 1'b1;
        #1;
        chk("f_cyc_rdy", {63'd0, b1.f_cyc_o}, 64'd0);
        tick();
        b1.inst_ready_i = 1'b0;
        chk("f_cnt3",  {61'd0, b1.count_o},  64'd3);
        chk("f_pc1",   {2'b0, b1.inst_pc_o}, {2'b0, wa(B0 + 4)});
        chk("f_reopen", {63'd0, b1.f_cyc_o}, 64'd1);
        tick();
        chk("f_refill", {61'd0, b1.count_o}, 64'd4);
        chk("f_adr2",  {2'b0, b1.f_adr_o},   {2'b0, wa(B0 + 20)});

        // ---- redirect at count 3 with ack high ----
        reset1(1'b1, 1'b0);
        repeat (3) tick();
        chk("r_cnt3", {61'd0, b1.count_o}, 64'd3);
        b1.redir_i      = 1'b1;
        b1.redir_adr_i  = wa(64'h1000);
        b1.inst_ready_i = 1'b1;
        #1;
        chk("r_valid_during", {63'd0, b1.inst_valid_o}, 64'd0);
        tick();
        b1.redir_i = 1'b0;
        chk("r_cnt0",  {61'd0, b1.count_o},  64'd0);
        chk("r_adr",   {2'b0, b1.f_adr_o},   {2'b0, wa(64'h1000)});
        chk("r_valid0", {63'd0, b1.inst_valid_o}, 64'd0);
        tick();
        chk("r_valid1", {63'd0, b1.inst_valid_o}, 64'd1);
        chk("r_pc",    {2'b0, b1.inst_pc_o}, {2'b0, wa(64'h1000)});
        chk("r_inst",  {32'd0, b1.inst_o},   {32'd0, mem_word(wa(64'h1000))});

`ifdef STAGE_F_PREFETCH_BUS_ERR_EN
        // ---- bus error on FF08, halt, restart by redirect ----
        reset1(1'b1, 1'b0);
        repeat (2) tick();
        b1.f_err_i = 1'b1;
        tick();
        b1.f_err_i = 1'b0;
        chk("e_cyc0",  {63'd0, b1.f_cyc_o}, 64'd0);
        chk("e_adr",   {2'b0, b1.f_adr_o},  {2'b0, wa(B0 + 8)});
        chk("e_cnt",   {61'd0, b1.count_o}, 64'd3);
        b1.inst_ready_i = 1'b1;
        repeat (2) tick();
        b1.inst_ready_i = 1'b0;
        chk("e_pc",    {2'b0, b1.inst_pc_o}, {2'b0, wa(B0 + 8)});
        chk("e_fault", {63'd0, b1.inst_fault_o}, 64'd1);
        chk("e_inst",  {32'd0, b1.inst_o}, 64'd0);
        chk("e_halt",  {63'd0, b1.f_cyc_o}, 64'd0);
        b1.redir_i     = 1'b1;
        b1.redir_adr_i = wa(64'h2000);
        tick();
        b1.redir_i = 1'b0;
        chk("e_cyc1",  {63'd0, b1.f_cyc_o}, 64'd1);
        chk("e_radr",  {2'b0, b1.f_adr_o},  {2'b0, wa(64'h2000)});
        tick();
        chk("e_rpc",   {2'b0, b1.inst_pc_o}, {2'b0, wa(64'h2000)});
        chk("e_nofault", {63'd0, b1.inst_fault_o}, 64'd0);
`endif

        // ---- wrap-around then reset mid-burst (second instance) ----
        rst2_n = 1'b1;
        tick();
        chk("x_adr0", {2'b0, b2.f_adr_o}, {2'b0, wa(BW)});
        tick();
        chk("x_adr1", {2'b0, b2.f_adr_o}, {2'b0, wa(BW + 4)});
        tick();
        chk("x_wrap", {2'b0, b2.f_adr_o}, 64'd0);
        chk("x_pc1",  {2'b0, b2.inst_pc_o}, {2'b0, wa(BW + 4)});
        tick();
        chk("x_adr3", {2'b0, b2.f_adr_o}, 64'd1);
        chk("x_pc2",  {2'b0, b2.inst_pc_o}, 64'd0);
        #2;
        rst2_n = 1'b0;
        #1;
        chk("x_rst_cyc", {63'd0, b2.f_cyc_o}, 64'd0);
        chk("x_rst_cnt", {61'd0, b2.count_o}, 64'd0);
        tick();
        rst2_n = 1'b1;
        tick();
        chk("x_re_cyc", {63'd0, b2.f_cyc_o}, 64'd1);
        chk("x_re_adr", {2'b0, b2.f_adr_o}, {2'b0, wa(BW)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stage_f_prefetch.md
Name: stage_f_prefetch

Overview:
- Parametrised successor to the Polaris single-fetch instruction stage.
- Drives the F-bus (f_cyc_o / f_ack_i / f_adr_o) from a configurable reset vector.
- Buffers fetched instruction words in a DEPTH-entry prefetch FIFO that feeds decode through a valid/ready handshake.
- Accepts a redirect (branch/trap target) that flushes the FIFO and restarts fetch.

Parameters:
- AW, 64, address width in bits; the bus carries word address bits [AW-1:2].
- RESET_VECTOR, 64'hFFFF_FFFF_FFFF_FF00, byte address of the first fetch after reset; bits [1:0] ignored.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- f_cyc_o  out  1  F-bus cycle request.
- f_adr_o  out  AW-2  F-bus word address [AW-1:2].
- f_ack_i  in  1  F-bus acknowledge; completes the beat in the same cycle.
- f_dat_i  in  32  instruction word; valid when f_cyc_o && f_ack_i.
- redir_i  in  1  redirect strobe, one cycle.
- redir_adr_i  in  AW-2  redirect word address.
- inst_valid_o  out  1  FIFO head valid.
- inst_o  out  32  FIFO head instruction.
- inst_pc_o  out  AW-2  word address of FIFO head.
- inst_ready_i  in  1  decode accepts head.
- count_o  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset asserted (reset_i=0), asynchronous. Forced values: f_cyc_o=0, inst_valid_o=0, count_o=0, fetch address=RESET_VECTOR[AW-1:2], run=0, FIFO empty.
- Reset release:
  - run is set at the first rising edge after reset_i goes high.
  - f_cyc_o=1 from the following cycle, with f_adr_o = RESET_VECTOR[AW-1:2].
- f_cyc_o = run && count != DEPTH. It is combinational from registers only and never depends on f_ack_i or inst_ready_i.
- Fetch beat: f_cyc_o && f_ack_i at the clock edge, with redir_i=0.
  - Push {f_dat_i, f_adr_o} into the FIFO.
  - Fetch address increments by 1 word.
- Wait states: f_cyc_o=1 and f_ack_i=0.
  - f_adr_o is held stable.
  - No push occurs.
  - f_cyc_o stays high indefinitely.
- Back-to-back: with f_ack_i held high and FIFO not full, one word per cycle and the address advances every cycle.
- Wrap-around: the address increments modulo 2^(AW-2), so all-ones wraps to 0 with no error.
- Dequeue: inst_valid_o && inst_ready_i pops the head.
  - inst_o and inst_pc_o show the new head next cycle.
  - They are don't-care when inst_valid_o=0.
- Simultaneous push and pop: count unchanged and data order preserved. FIFO pointers wrap modulo DEPTH.
- Full: count=DEPTH, so f_cyc_o=0 in that cycle.
  - A pop in that cycle reopens fetch next cycle.
  - f_adr_o keeps the next unfetched address.
- Redirect (redir_i=1 at an edge). Redirect has priority over push and pop.
  - FIFO is flushed (count=0).
  - Fetch address = redir_adr_i.
  - Data acked in the same cycle is discarded.
  - inst_valid_o is forced 0 combinationally while redir_i=1, so no pop occurs.
  - Fetch resumes at redir_adr_i on the next cycle; first valid output at the earliest one cycle after that.
- redir_i during reset is ignored.
- Reset mid-operation: immediate return to the reset state. Any FIFO contents and any in-progress bus cycle are abandoned.

Optional Feature:
- Macro: STAGE_F_PREFETCH_BUS_ERR_EN.
- When defined:
  - Adds port f_err_i (in, 1) and output inst_fault_o (out, 1, qualifies the head entry).
  - f_cyc_o && f_err_i pushes an entry with fault=1, inst_o=0 and pc=f_adr_o; f_err_i has priority over f_ack_i.
  - Fetch then halts: f_cyc_o=0 until redir_i or reset, and the address does not advance.
- When undefined:
  - Neither port exists.
  - Every pushed entry is a normal instruction.

Test Plan:
- Reset/start (default params): hold reset_i=0 for 1 clock, f_ack_i=1, inst_ready_i=1 -> f_cyc_o=0 during reset. After release, addresses FF00, FF04, FF08 are issued on consecutive cycles and inst_pc_o follows one cycle behind.
- Wait states: drop f_ack_i for 2 cycles while fetching FF04 -> f_adr_o holds FF04 and f_cyc_o stays 1. On re-ack the address advances to FF08, and no duplicate or missing FIFO entries appear.
- Fill/backpressure (DEPTH=4): inst_ready_i=0, f_ack_i=1 -> words FF00..FF0C pushed, count_o=4, f_cyc_o=0. Raise inst_ready_i for 1 cycle -> FF00 dequeued, then FF10 fetched.
- Redirect: at count_o=3 with f_ack_i=1, pulse redir_i with redir_adr_i=0x1000>>2 -> inst_valid_o=0 that cycle, count_o=0, acked data dropped. Next fetch is at 0x1000 and the first dequeued pc is 0x1000.
- Wrap and reset mid-op: RESET_VECTOR=64'hFFFF_FFFF_FFFF_FFF8 -> fetches FFF8, FFFC, then 0x0. Then assert reset_i=0 mid-burst -> f_cyc_o=0 and count_o=0 immediately, and after release the next fetch is FFF8.
- With STAGE_F_PREFETCH_BUS_ERR_EN defined: assert f_err_i on the FF08 fetch -> entry with inst_fault_o=1 and pc FF08, f_cyc_o=0 until a redirect to 0x2000 restarts fetch there.
